// File: rtl/clk_p.sv
// rtl/clk_p.sv - interval timer for the traffic-light controller
// Counts timebase ticks since the last clear and flags the short and long phase intervals.
module clk_p #(
  parameter int CNT_W   = 4,
  parameter int T_SHORT = 2,
  parameter int T_LONG  = 10
) (
  input  logic CLK,
  input  logic RST,
  input  logic TC_TIMEBASE,
  input  logic RST_Q,
  output logic TC_2,
  output logic TC_10
);

  localparam logic [CNT_W-1:0] SHORT_C = CNT_W'(T_SHORT);
  localparam logic [CNT_W-1:0] LONG_C  = CNT_W'(T_LONG);

  logic [CNT_W-1:0] cnt;

  // Clear wins over a coincident tick; the count saturates at T_LONG instead of wrapping.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (RST_Q) begin
      cnt <= '0;
    end else if (TC_TIMEBASE && (cnt < LONG_C)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign TC_2  = (cnt >= SHORT_C);
  assign TC_10 = (cnt >= LONG_C);

endmodule

// File: tb/tb_clk_p.sv
// tb/tb_clk_p.sv - self-checking testbench for clk_p
// Reference model: ticks since last clear, capped at T_LONG.
module tb_clk_p;

  localparam int T_SHORT = 2;
  localparam int T_LONG  = 10;

  logic tb_CLK;
  logic rst;
  logic tc_timebase;
  logic rst_q;
  logic tc_2;
  logic tc_10;

  int assertions;
  int failures;
  int model_ticks;

  clk_p #(.CNT_W(4), .T_SHORT(T_SHORT), .T_LONG(T_LONG)) dut (
    .CLK         (tb_CLK),
    .RST         (rst),
    .TC_TIMEBASE (tc_timebase),
    .RST_Q       (rst_q),
    .TC_2        (tc_2),
    .TC_10       (tc_10)
  );

  initial begin
    tb_CLK = 1'b0;
    forever #5 tb_CLK = ~tb_CLK;
  end

  // Drive one cycle of inputs at the falling edge, update the model at the rising edge.
  task automatic drive(input logic tick, input logic clr);
    @(negedge tb_CLK);
    tc_timebase = tick;
    rst_q       = clr;
    @(posedge tb_CLK);
    if (!rst) begin
      if (clr)
        model_ticks = 0;
      else if (tick)
        model_ticks = (model_ticks + 1 > T_LONG) ? T_LONG : model_ticks + 1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rst_q = 1'b1;
    tc_timebase = 1'b0;
    model_ticks = 0;
    #1;
    while ($time < 113) begin
      assertions++;
      if (tc_2 !== 1'b0 || tc_10 !== 1'b0) begin
        failures++;
        $display("FAIL reset: tc_2=%b tc_10=%b, required 0 0 at t=%0t", tc_2, tc_10, $time);
      end
      #4;
    end
    rst = 1'b0;
  endtask

  task automatic test_hold_clear();
    for (int i = 0; i < 120; i++) begin
      drive((i % 10) == 9, 1'b1);
      assertions++;
      if (tc_2 !== 1'b0 || tc_10 !== 1'b0) begin
        failures++;
        $display("FAIL hold_clear: cycle %0d tc_2=%b tc_10=%b, required 0 0", i, tc_2, tc_10);
      end
    end
  endtask

  task automatic test_count_up();
    int ticks;
    ticks = 0;
    for (int i = 0; i < 150; i++) begin
      drive((i % 10) == 9, 1'b0);
      if ((i % 10) == 9) ticks++;
      assertions++;
      if (tc_2 !== (ticks >= T_SHORT) || tc_10 !== (ticks >= T_LONG)) begin
        failures++;
        $display("FAIL count_up: ticks %0d tc_2=%b tc_10=%b, required %b %b",
                 ticks, tc_2, tc_10, ticks >= T_SHORT, ticks >= T_LONG);
      end
    end
  endtask

  task automatic test_clear_with_tick();
    drive(1'b1, 1'b1);
    assertions++;
    if (tc_2 !== 1'b0 || tc_10 !== 1'b0) begin
      failures++;
      $display("FAIL clear_with_tick: tc_2=%b tc_10=%b, required 0 0", tc_2, tc_10);
    end
    drive(1'b1, 1'b0);
    assertions++;
    if (tc_2 !== 1'b0) begin
      failures++;
      $display("FAIL first_tick_after_clear: tc_2=%b, required 0", tc_2);
    end
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    assertions++;
    if (tc_2 !== 1'b1 || tc_10 !== 1'b0) begin
      failures++;
      $display("FAIL second_tick_after_clear: tc_2=%b tc_10=%b, required 1 0", tc_2, tc_10);
    end
  endtask

  task automatic test_held_tick();
    drive(1'b0, 1'b1);
    for (int i = 1; i <= 13; i++) begin
      drive(1'b1, 1'b0);
      assertions++;
      if (tc_2 !== (i >= T_SHORT) || tc_10 !== (i >= T_LONG)) begin
        failures++;
        $display("FAIL held_tick: cycle %0d tc_2=%b tc_10=%b, required %b %b",
                 i, tc_2, tc_10, i >= T_SHORT, i >= T_LONG);
      end
    end
  endtask

  task automatic test_random();
    logic tick;
    logic clr;
    for (int i = 0; i < 2000; i++) begin
      tick = ($urandom_range(0, 2) == 0);
      clr  = ($urandom_range(0, 24) == 0);
      drive(tick, clr);
      assertions++;
      if (tc_2 !== (model_ticks >= T_SHORT) || tc_10 !== (model_ticks >= T_LONG)) begin
        failures++;
        $display("FAIL random: cycle %0d model %0d tc_2=%b tc_10=%b, required %b %b",
                 i, model_ticks, tc_2, tc_10, model_ticks >= T_SHORT, model_ticks >= T_LONG);
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 12; i++) drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    assertions++;
    if (tc_10 !== 1'b1 || tc_2 !== 1'b1) begin
      failures++;
      $display("FAIL async_reset_setup: tc_2=%b tc_10=%b, required 1 1", tc_2, tc_10);
    end
    @(negedge tb_CLK);
    #2 rst = 1'b1;
    #1;
    assertions++;
    if (tc_2 !== 1'b0 || tc_10 !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: tc_2=%b tc_10=%b, required 0 0 before next edge", tc_2, tc_10);
    end
    model_ticks = 0;
    @(negedge tb_CLK);
    rst = 1'b0;
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    assertions++;
    if (tc_2 !== 1'b1 || tc_10 !== 1'b0) begin
      failures++;
      $display("FAIL after_async_reset: tc_2=%b tc_10=%b, required 1 0", tc_2, tc_10);
    end
  endtask

  initial begin
    assertions = 0;
    failures = 0;
    test_reset();
    test_hold_clear();
    test_count_up();
    test_clear_with_tick();
    test_held_tick();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
